// File: rtl/csr_trap_ctrl.sv
// SYSTEM-instruction sequencer between EXU and the CSR file: CSR read-modify-write,
// ecall and mret, with LSU drain, trap/return strobes and a PC redirect plus flush.
module csr_trap_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CSR_AW      = 12,
  parameter int unsigned ECALL_CAUSE = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [2:0]        csr_op_i,
  input  logic              is_ecall_i,
  input  logic              is_mret_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic              lsu_busy_i,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              ecall_o,
  output logic              mret_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic [XLEN-1:0]   mcause_o,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_data_o,
  input  logic              wb_ready_i,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  input  logic              redirect_ready_i,
  output logic              flush_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_EXEC,
    S_WB,
    S_REDIR
  } state_t;

  state_t              state_q;
  logic [XLEN-1:0]     pc_q;
  logic [2:0]          op_q;
  logic                ecall_q;
  logic                mret_q;
  logic [CSR_AW-1:0]   addr_q;
  logic [4:0]          idx_q;
  logic [XLEN-1:0]     rs1_q;
  logic [XLEN-1:0]     old_q;
  logic [XLEN-1:0]     tgt_q;

  logic                exec_c;
  logic                is_csr_c;
  logic                csr_hit_c;
  logic                no_write_c;
  logic [XLEN-1:0]     old_c;
  logic [XLEN-1:0]     src_c;
  logic [XLEN-1:0]     wdata_c;

  // Decode of the latched instruction; only meaningful in EXEC.
  assign exec_c     = (state_q == S_EXEC);
  assign is_csr_c   = !ecall_q && !mret_q && (op_q != 3'd0);
  assign csr_hit_c  = (addr_q == CSR_AW'(12'h300)) || (addr_q == CSR_AW'(12'h305)) ||
                      (addr_q == CSR_AW'(12'h341)) || (addr_q == CSR_AW'(12'h342));
  assign old_c      = csr_hit_c ? csr_rdata_i : '0;
  assign src_c      = op_q[2] ? XLEN'(idx_q) : rs1_q;
  // Set/clear forms with rs1/zimm of zero must not write (read-only side effects).
  assign no_write_c = op_q[1] && (idx_q == 5'd0);

  always_comb begin
    wdata_c = old_c;
    case (op_q[1:0])
      2'b01:   wdata_c = src_c;
      2'b10:   wdata_c = old_c | src_c;
      2'b11:   wdata_c = old_c & ~src_c;
      default: wdata_c = old_c;
    endcase
  end

  assign csr_raddr_o      = addr_q;
  assign csr_waddr_o      = addr_q;
  assign csr_wdata_o      = wdata_c;
  assign csr_we_o         = exec_c && is_csr_c && csr_hit_c && (op_q[1:0] != 2'b00) && !no_write_c;
  assign ecall_o          = exec_c && ecall_q;
  assign mret_o           = exec_c && !ecall_q && mret_q;
  assign mepc_o           = ecall_o ? pc_q : '0;
  assign mcause_o         = ecall_o ? XLEN'(ECALL_CAUSE) : '0;
  assign in_ready_o       = (state_q == S_IDLE);
  assign wb_valid_o       = (state_q == S_WB);
  assign wb_data_o        = wb_valid_o ? old_q : '0;
  assign redirect_valid_o = (state_q == S_REDIR);
  assign flush_o          = redirect_valid_o;
  assign redirect_pc_o    = redirect_valid_o ? tgt_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      op_q    <= '0;
      ecall_q <= 1'b0;
      mret_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      rs1_q   <= '0;
      old_q   <= '0;
      tgt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            pc_q    <= pc_i;
            op_q    <= csr_op_i;
            ecall_q <= is_ecall_i;
            mret_q  <= is_mret_i;
            addr_q  <= csr_addr_i;
            idx_q   <= rs1_idx_i;
            rs1_q   <= rs1_data_i;
            state_q <= lsu_busy_i ? S_DRAIN : S_EXEC;
          end
        end
        S_DRAIN: begin
          if (!lsu_busy_i) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (ecall_q) begin
            tgt_q   <= mtvec_i;
            state_q <= S_REDIR;
          end else if (mret_q) begin
            tgt_q   <= mepc_i;
            state_q <= S_REDIR;
          end else if (op_q != 3'd0) begin
            old_q   <= old_c;
            state_q <= S_WB;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WB: begin
          if (wb_ready_i) state_q <= S_IDLE;
        end
        S_REDIR: begin
          if (redirect_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Sits between EXU and the CSR register file. Accepts one SYSTEM-class instruction at a time: CSR read-modify-write, ecall or mret.
- For CSR ops: computes the CSR write value and write strobe, and returns the old CSR value for rd writeback.
- For ecall/mret: drains outstanding LSU traffic, pulses the trap/return strobes with mepc/mcause, then issues a PC redirect plus pipeline flush.

Parameters:
XLEN, 32, data/PC width
CSR_AW, 12, CSR address width
ECALL_CAUSE, 11, mcause value written on ecall (environment call from M-mode)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-low
in_valid_i  in  1  EXU presents a SYSTEM instruction
in_ready_o  out  1  block can accept
pc_i  in  XLEN  instruction PC
csr_op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000 = no CSR op
is_ecall_i  in  1  instruction is ecall
is_mret_i  in  1  instruction is mret
csr_addr_i  in  CSR_AW  CSR address
rs1_idx_i  in  5  rs1 index; also zimm for immediate forms
rs1_data_i  in  XLEN  rs1 value
lsu_busy_i  in  1  LSU has an outstanding transaction
csr_raddr_o  out  CSR_AW  latched CSR address, for combinational read
csr_rdata_i  in  XLEN  CSR read data
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
csr_we_o  out  1  CSR write strobe
csr_waddr_o  out  CSR_AW  CSR write address
csr_wdata_o  out  XLEN  CSR write value
ecall_o  out  1  trap strobe to CSR file
mret_o  out  1  return strobe to CSR file
mepc_o  out  XLEN  PC to save on ecall
mcause_o  out  XLEN  cause to save on ecall
wb_valid_o  out  1  rd writeback valid
wb_data_o  out  XLEN  old CSR value
wb_ready_i  in  1  WBU accepts
redirect_valid_o  out  1  redirect request
redirect_pc_o  out  XLEN  redirect target
redirect_ready_i  in  1  IFU accepts redirect
flush_o  out  1  flush younger instructions

Behaviour:

Reset (rst_i==0 at posedge, from any state):
- State goes to IDLE.
- All strobes, valids, flush, mepc_o, mcause_o, wb_data_o and redirect_pc_o are 0.
- Any in-flight instruction is dropped with no CSR write.

States:
- IDLE: in_ready_o=1, others 0. On in_valid_i&in_ready_o, latch all inputs. Next state is DRAIN if lsu_busy_i==1, else EXEC.
- DRAIN: in_ready_o=0. Stay until lsu_busy_i==0, then go to EXEC. Every instruction class drains, not only ecall/mret.
- EXEC: exactly one cycle; strobes are combinational in this state only.
- WB: wb_valid_o=1, wb_data_o stable. Go to IDLE on wb_ready_i.
- REDIRECT: redirect_valid_o=1, flush_o=1, redirect_pc_o stable. Go to IDLE on redirect_ready_i.

Classification priority: is_ecall_i > is_mret_i > csr_op_i!=0. If all are zero, EXEC goes to IDLE with no effect.

EXEC, ecall:
- ecall_o=1, mepc_o=latched PC, mcause_o=ECALL_CAUSE.
- Capture redirect target = mtvec_i, then go to REDIRECT.

EXEC, mret:
- mret_o=1.
- Capture redirect target = mepc_i, then go to REDIRECT.

EXEC, CSR op:
- csr_raddr_o = latched address. Capture old = csr_rdata_i into wb_data_o.
- Source operand src = rs1_data (RW/RS/RC) or zero-extended zimm (immediate forms).
- Write value: RW → src; RS → old|src; RC → old&~src.
- csr_we_o=1 with csr_waddr_o = latched address, except the write is suppressed for RS/RC/RSI/RCI when rs1_idx==0.
- Next state is WB. Old value is sampled before the CSR file updates at the same edge.

Supported CSRs: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause. Any other address returns old=0 and csr_we_o stays 0.

No new instruction is accepted outside IDLE; in_ready_o=0 in all other states.

Test Plan:
- CSR RW: csrrw, addr 0x305, rs1=0x8000_0100, CSR old 0x0 → EXEC: csr_we_o=1, csr_wdata_o=0x8000_0100; WB: wb_data_o=0x0.
- RS/RC: csrrs 0x300, rs1_data=0x8, old 0x1800 → wdata 0x1808. Then csrrc with rs1_data=0x1800, old 0x1808 → wdata 0x8. csrrsi with zimm=0 → csr_we_o=0, wb_data_o=old.
- ecall with drain: pc=0x8000_0040, lsu_busy_i high for 3 cycles, mtvec=0x8000_0200 → DRAIN for 3 cycles; then ecall_o pulse with mepc_o=0x8000_0040, mcause_o=11; then redirect_pc_o=0x8000_0200 with flush_o=1 until redirect_ready_i.
- mret: mepc_i=0x8000_0044 → mret_o for one cycle, redirect_pc_o=0x8000_0044. With is_ecall_i and is_mret_i both high → ecall path taken.
- Backpressure: hold wb_ready_i=0 for 5 cycles → wb_valid_o and wb_data_o stable, in_ready_o=0, no second csr_we_o.
- Reset mid-op: assert rst_i=0 while in REDIRECT → next cycle IDLE, redirect_valid_o=0, flush_o=0, in_ready_o=1.
